cla_pipe_addsub: RTL and testbench



---
 rtl/cla_pipe_addsub.sv | 122 ++++++++++++
 tb/tb_cla_pipe_addsub.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor.
// The operand is cut into BLK-bit lookahead blocks and block k is resolved in
// pipeline stage k, using the carry registered by stage k-1.
// Each stage keeps a rotating word x: the A bits still to be added sit at
// the bottom, and finished sum blocks are shifted in from the top. After
// NSTG stages the sum blocks sit in their natural positions. The y word
// holds the B' bits still to be added and shifts down with zero fill.
module cla_pipe_addsub #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int NSTG = WIDTH / BLK;

  logic [WIDTH-1:0] x_q [NSTG];
  logic [WIDTH-1:0] y_q [NSTG];
  logic             c_q [NSTG];
  logic             v_q [NSTG];
  logic             ovf_q;

  logic [WIDTH-1:0] x_d [NSTG];
  logic [WIDTH-1:0] y_d [NSTG];
  logic             c_d [NSTG];
  logic             ovf_d;

  logic [WIDTH-1:0] si_x [NSTG];
  logic [WIDTH-1:0] si_y [NSTG];
  logic             si_c [NSTG];

  logic [BLK-1:0]   p;
  logic [BLK-1:0]   g;
  logic [BLK:0]     cc;
  logic [WIDTH-1:0] sw;

  logic             adv;

  // The whole pipeline moves together whenever the output slot is free or being taken.
  assign adv      = out_ready | ~v_q[NSTG-1];
  assign in_ready = adv;

  // Stage inputs: stage 0 sees the conditioned operands, later stages the previous register.
  always_comb begin
    si_x[0] = a_in;
    si_y[0] = sub ? ~b_in : b_in;
    si_c[0] = c_in ^ sub;
    for (int k = 1; k < NSTG; k++) begin
      si_x[k] = x_q[k-1];
      si_y[k] = y_q[k-1];
      si_c[k] = c_q[k-1];
    end
  end

  // Per-stage block lookahead: resolve the low block and rotate the sum block in on top.
  always_comb begin
    p     = '0;
    g     = '0;
    cc    = '0;
    sw    = '0;
    ovf_d = 1'b0;
    for (int k = 0; k < NSTG; k++) begin
      p     = si_x[k][BLK-1:0] ^ si_y[k][BLK-1:0];
      g     = si_x[k][BLK-1:0] & si_y[k][BLK-1:0];
      cc[0] = si_c[k];
      for (int j = 0; j < BLK; j++) begin
        cc[j+1] = g[j] | (p[j] & cc[j]);
      end
      sw          = '0;
      sw[BLK-1:0] = p ^ cc[BLK-1:0];
      x_d[k]      = (si_x[k] >> BLK) | (sw << (WIDTH - BLK));
      y_d[k]      = si_y[k] >> BLK;
      c_d[k]      = cc[BLK];
      // Last block holds the MSB: overflow is carry-in XOR carry-out of that bit.
      if (k == NSTG - 1) begin
        ovf_d = cc[BLK] ^ cc[BLK-1];
      end
    end
  end

  // Stage registers: clear on reset, advance together only when adv is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSTG; k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < NSTG; k++) begin
        x_q[k] <= x_d[k];
        y_q[k] <= y_d[k];
        c_q[k] <= c_d[k];
      end
      v_q[0] <= in_valid;
      for (int k = 1; k < NSTG; k++) begin
        v_q[k] <= v_q[k-1];
      end
      ovf_q <= ovf_d;
    end
  end

  assign s         = x_q[NSTG-1];
  assign co        = c_q[NSTG-1];
  assign ovf       = ovf_q;
  assign out_valid = v_q[NSTG-1];

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub: a 16/4 instance and an 8/8 instance share clock
// and reset. Expected results come from plain integer arithmetic.
module tb_cla_pipe_addsub;

  typedef struct {
    logic [15:0] s;
    logic        co;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        iv16 = 1'b0, or16 = 1'b1, cin16 = 1'b0, sub16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        ir16, ov16, co16, ovf16;
  logic [15:0] s16;

  logic        iv8 = 1'b0, or8 = 1'b1, cin8 = 1'b0, sub8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ir8, ov8, co8, ovf8;
  logic [7:0]  s8;

  cla_pipe_addsub #(.WIDTH(16), .BLK(4)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .a_in(a16), .b_in(b16), .c_in(cin16), .sub(sub16),
    .out_valid(ov16), .out_ready(or16), .s(s16), .co(co16), .ovf(ovf16));

  cla_pipe_addsub #(.WIDTH(8), .BLK(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .a_in(a8), .b_in(b8), .c_in(cin8), .sub(sub8),
    .out_valid(ov8), .out_ready(or8), .s(s8), .co(co8), .ovf(ovf8));

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   exact_lat  = 1'b0;
  bit   rand_stall = 1'b0;
  exp_t q [2][$];
  bit   [1:0] pstall = '0;
  logic [15:0] ps [2];
  logic pco [2];
  logic povf [2];
  logic pov [2];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference: integer arithmetic for the unsigned result/carry, signed range for overflow.
  function automatic exp_t model(input int w, input int a, input int b, input bit cin, input bit sb);
    exp_t e;
    int mask, half, r, sa, sbv, sr;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    r    = sb ? (a - b - int'(cin)) : (a + b + int'(cin));
    e.s  = 16'(r & mask);
    e.co = sb ? (a >= b + int'(cin)) : (r > mask);
    sa   = (a >= half) ? a - (1 << w) : a;
    sbv  = (b >= half) ? b - (1 << w) : b;
    sr   = sb ? (sa - sbv - int'(cin)) : (sa + sbv + int'(cin));
    e.ovf = (sr >= half) || (sr < -half);
    e.cyc = 0;
    return e;
  endfunction

  task automatic mon(input int id, input int nstg, input int w,
                     input logic ov, input logic orr, input logic ir, input logic iv,
                     input logic [15:0] so, input logic coo, input logic ovfo,
                     input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sb);
    exp_t e;
    check($sformatf("in_ready_w%0d", w), 32'(ir), 32'(!(ov && !orr)));
    if (pstall[id]) begin
      check($sformatf("hold_s_w%0d", w), 32'(so), 32'(ps[id]));
      check($sformatf("hold_co_w%0d", w), 32'(coo), 32'(pco[id]));
      check($sformatf("hold_ovf_w%0d", w), 32'(ovfo), 32'(povf[id]));
      check($sformatf("hold_valid_w%0d", w), 32'(ov), 32'(pov[id]));
    end
    if (ov && orr) begin
      if (q[id].size() == 0) begin
        check($sformatf("unexpected_out_w%0d_queue_size", w), 32'(q[id].size()), 32'd1);
      end else begin
        e = q[id].pop_front();
        check($sformatf("s_w%0d", w), 32'(so), 32'(e.s));
        check($sformatf("co_w%0d", w), 32'(coo), 32'(e.co));
        check($sformatf("ovf_w%0d", w), 32'(ovfo), 32'(e.ovf));
        if (exact_lat)
          check($sformatf("latency_w%0d", w), 32'(cyc - e.cyc), 32'(nstg));
        else
          check($sformatf("latency_min_w%0d", w), 32'((cyc - e.cyc) >= nstg), 32'd1);
      end
    end
    if (iv && ir) begin
      e = model(w, int'(a), int'(b), cin, sb);
      e.cyc = cyc;
      q[id].push_back(e);
    end
    pstall[id] = ov && !orr;
    ps[id]   = so;
    pco[id]  = coo;
    povf[id] = ovfo;
    pov[id]  = ov;
  endtask

  // Single compare process, sampling on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q[0].delete();
      q[1].delete();
      pstall = '0;
    end else begin
      mon(0, 4, 16, ov16, or16, ir16, iv16, s16, co16, ovf16, a16, b16, cin16, sub16);
      mon(1, 1, 8, ov8, or8, ir8, iv8, {8'h00, s8}, co8, ovf8, {8'h00, a8}, {8'h00, b8}, cin8, sub8);
    end
  end

  // Downstream ready: held high, or randomly toggled during stall phases.
  initial forever begin
    @(posedge clk);
    #1;
    or16 = rand_stall ? 1'($urandom_range(0, 1)) : 1'b1;
    or8  = rand_stall ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    a16 = a; b16 = b; cin16 = ci; sub16 = sb; iv16 = 1'b1;
    while (!acc && n < 500) begin
      @(negedge clk);
      acc = ir16;
      @(posedge clk);
      #1;
      n++;
    end
    check("send16_accepted", 32'(acc), 32'd1);
    iv16 = 1'b0;
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sb);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    a8 = a; b8 = b; cin8 = ci; sub8 = sb; iv8 = 1'b1;
    while (!acc && n < 500) begin
      @(negedge clk);
      acc = ir8;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("send8_accepted", 32'(acc), 32'd1);
    iv8 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q[0].size() != 0 || q[1].size() != 0) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_left", 32'(q[0].size() + q[1].size()), 32'd0);
  endtask

  initial begin
    exp_t e;
    logic [7:0] bb;
    int j;

    #2 rst_n = 1'b0;
    #5;
    check("rst_out_valid16", 32'(ov16), 32'd0);
    check("rst_s16", 32'(s16), 32'd0);
    check("rst_co16", 32'(co16), 32'd0);
    check("rst_ovf16", 32'(ovf16), 32'd0);
    check("rst_in_ready16", 32'(ir16), 32'd1);
    check("rst_out_valid8", 32'(ov8), 32'd0);
    check("rst_s8", 32'(s8), 32'd0);
    check("rst_in_ready8", 32'(ir8), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Pin the reference model against hand-computed results.
    e = model(16, 'hFFFF, 'h0001, 1'b0, 1'b0);
    check("pin1_s", 32'(e.s), 32'h0000); check("pin1_co", 32'(e.co), 32'd1); check("pin1_ovf", 32'(e.ovf), 32'd0);
    e = model(16, 'h7FFF, 'h0001, 1'b0, 1'b0);
    check("pin2_s", 32'(e.s), 32'h8000); check("pin2_co", 32'(e.co), 32'd0); check("pin2_ovf", 32'(e.ovf), 32'd1);
    e = model(16, 'h0005, 'h0007, 1'b0, 1'b1);
    check("pin3_s", 32'(e.s), 32'hFFFE); check("pin3_co", 32'(e.co), 32'd0); check("pin3_ovf", 32'(e.ovf), 32'd0);
    e = model(16, 'h8000, 'h0001, 1'b0, 1'b1);
    check("pin4_s", 32'(e.s), 32'h7FFF); check("pin4_co", 32'(e.co), 32'd1); check("pin4_ovf", 32'(e.ovf), 32'd1);
    e = model(8, 'h80, 'h01, 1'b0, 1'b1);
    check("pin5_s", 32'(e.s), 32'h007F); check("pin5_co", 32'(e.co), 32'd1); check("pin5_ovf", 32'(e.ovf), 32'd1);
    e = model(8, 'h01, 'h01, 1'b1, 1'b1);
    check("pin6_s", 32'(e.s), 32'h00FF); check("pin6_co", 32'(e.co), 32'd0); check("pin6_ovf", 32'(e.ovf), 32'd0);

    @(posedge clk);
    #1;

    // Directed corner vectors, then eight back-to-back operations.
    exact_lat = 1'b1;
    send16(16'hFFFF, 16'h0001, 1'b0, 1'b0); idle(6);
    send16(16'h7FFF, 16'h0001, 1'b0, 1'b0); idle(6);
    send16(16'h0005, 16'h0007, 1'b0, 1'b1); idle(6);
    send16(16'h8000, 16'h0001, 1'b0, 1'b1); idle(6);
    for (int i = 0; i < 8; i++)
      send16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    drain();

    // Random backpressure with occasional bubbles.
    exact_lat = 1'b0;
    rand_stall = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end
    rand_stall = 1'b0;
    drain();

    // Reset with operations in flight.
    exact_lat = 1'b1;
    idle(2);
    send16(16'h1234, 16'h1111, 1'b0, 1'b0);
    send16(16'h2222, 16'h0101, 1'b1, 1'b1);
    send16(16'hAAAA, 16'h5555, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("pre_reset_out_valid", 32'(ov16), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", 32'(ov16), 32'd0);
    check("async_reset_s", 32'(s16), 32'd0);
    check("async_reset_co", 32'(co16), 32'd0);
    check("async_reset_in_ready", 32'(ir16), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++)
      send16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    drain();

    // 8-bit single-stage instance: all A values against edge and random B values.
    for (int i = 0; i < 8192; i++) begin
      j = i >> 8;
      case (j)
        0:       bb = 8'h00;
        1:       bb = 8'hFF;
        2:       bb = 8'h80;
        3:       bb = 8'h7F;
        4:       bb = 8'h01;
        default: bb = 8'($urandom);
      endcase
      send8(8'(i), bb, 1'(i >> 13) ^ 1'($urandom), 1'($urandom));
    end
    drain();

    exact_lat = 1'b0;
    rand_stall = 1'b1;
    for (int i = 0; i < 200; i++)
      send8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    rand_stall = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
